// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and sampling helper
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RX pin synchroniser and bit sampler
// UART_RX_MAJORITY_EN selects a 2-of-3 vote over the last three synchronised values.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic CLK,
    input  logic rst,
    input  logic RX,
    output logic rxs,
    output logic sample_bit
);

    logic [1:0] sync_ff;

    // Idle-high reset so a released reset never looks like a start edge
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], RX};
        end
    end

    assign rxs = sync_ff[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxs};
        end
    end

    assign sample_bit = maj3(rxs, hist[0], hist[1]);
`else
    assign sample_bit = rxs;
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry valid/ready holding register
// Optional UART_RX_MAJORITY_EN enables majority-vote sampling in uart_rx_sync.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_active
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rxs;
    logic          rxs_d;
    logic          sample_bit;
    logic          expire;

    uart_rx_sync u_sync (
        .CLK        (CLK),
        .rst        (rst),
        .RX         (RX),
        .rxs        (rxs),
        .sample_bit (sample_bit)
    );

    assign expire = (cnt == CW'(1));

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rxs_d     <= 1'b1;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            rxs_d     <= rxs;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    // Only a fresh falling edge arms a frame; a held-low line stays idle
                    if (rxs_d && !rxs) begin
                        cnt       <= HALF_BIT;
                        state     <= ST_START;
                        rx_active <= 1'b1;
                    end
                end

                ST_START: begin
                    if (!expire) begin
                        cnt <= cnt - CW'(1);
                    end else if (!sample_bit) begin
                        cnt     <= FULL_BIT;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        state     <= ST_IDLE;
                        rx_active <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (!expire) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shift <= {sample_bit, shift[7:1]};
                        cnt   <= FULL_BIT;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                ST_STOP: begin
                    if (!expire) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state     <= ST_IDLE;
                        rx_active <= 1'b0;
                        if (!sample_bit) begin
                            frame_err <= 1'b1;
                        end else if (!valid || ready) begin
                            // A same-cycle take frees the register, so the new byte lands without loss
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    rx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-timing model
module tb_uart_rx;
    import uart_pkg::*;

    localparam int N   = UART_DEFAULT_CLKS_PER_BIT;
    localparam int H   = N / 2;
    localparam int LAT = 2 + H + 9 * N + 1;

    localparam int K_GOOD   = 0;
    localparam int K_FERR   = 1;
    localparam int K_OVR    = 2;
    localparam int K_ABSORB = 3;
    localparam int K_FALSE  = 4;

    logic       CLK   = 1'b0;
    logic       rst   = 1'b1;
    logic       RX    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_active;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .RX        (RX),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_active (rx_active)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         q_vcyc[$];
    logic [7:0] q_vdat[$];
    int         q_ferr[$];
    int         q_ovr[$];
    int         q_arise[$];
    int         q_afall[$];
    int         n_vhigh = 0;
    logic       valid_p = 1'b0;
    logic       act_p   = 1'b0;

    always @(negedge CLK) begin
        if (!rst) begin
            if (valid && !valid_p) begin
                q_vcyc.push_back(cyc);
                q_vdat.push_back(data);
            end
            if (valid) n_vhigh++;
            if (frame_err) q_ferr.push_back(cyc);
            if (overrun) q_ovr.push_back(cyc);
            if (rx_active && !act_p) q_arise.push_back(cyc);
            if (!rx_active && act_p) q_afall.push_back(cyc);
        end
        valid_p <= valid;
        act_p   <= rx_active;
    end

    task automatic clear_events();
        q_vcyc.delete();
        q_vdat.delete();
        q_ferr.delete();
        q_ovr.delete();
        q_arise.delete();
        q_afall.delete();
        n_vhigh = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives start, 8 data bits LSB first and the stop level; leaves RX at the stop level
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit glitch, output int fall);
        fall = cyc;
        RX = 1'b0;
        tick(N);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                RX = b[i];
                tick(H);
                RX = ~b[i];
                tick(1);
                RX = b[i];
                tick(N - H - 1);
            end else begin
                RX = b[i];
                tick(N);
            end
        end
        RX = stop_ok;
        tick(N);
    endtask

    // Expected outcome of one start edge, timed from the pin fall cycle
    task automatic expect_frame(input string tag, input int fall, input int kind, input logic [7:0] b);
        int t_end;
        t_end = (kind == K_FALSE) ? fall + 2 + H + 1 : fall + LAT;
        check({tag, "_act_rise_n"}, q_arise.size(), 1);
        if (q_arise.size() > 0) check({tag, "_act_rise_cyc"}, q_arise[0], fall + 3);
        check({tag, "_act_fall_n"}, q_afall.size(), 1);
        if (q_afall.size() > 0) check({tag, "_act_fall_cyc"}, q_afall[0], t_end);
        check({tag, "_valid_n"}, q_vcyc.size(), (kind == K_GOOD) ? 1 : 0);
        if (kind == K_GOOD && q_vcyc.size() > 0) begin
            check({tag, "_valid_cyc"}, q_vcyc[0], t_end);
            check({tag, "_data"}, int'(q_vdat[0]), int'(b));
        end
        check({tag, "_ferr_n"}, q_ferr.size(), (kind == K_FERR) ? 1 : 0);
        if (kind == K_FERR && q_ferr.size() > 0) check({tag, "_ferr_cyc"}, q_ferr[0], t_end);
        check({tag, "_ovr_n"}, q_ovr.size(), (kind == K_OVR) ? 1 : 0);
        if (kind == K_OVR && q_ovr.size() > 0) check({tag, "_ovr_cyc"}, q_ovr[0], t_end);
        clear_events();
    endtask

    initial begin
        int         fall;
        int         f2;
        int         dummy;
        int         mode;
        int         gap;
        int         glen;
        logic [7:0] b;

        tick(3);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_rx_active", int'(rx_active), 0);
        rst = 1'b0;
        tick(5);
        clear_events();

        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, fall);
        check("a5_valid_high_cycles", n_vhigh, 1);
        expect_frame("a5", fall, K_GOOD, 8'hA5);
        tick(10);

        fall = cyc;
        RX = 1'b0;
        tick(30);
        RX = 1'b1;
        tick(H + 20);
        expect_frame("glitch", fall, K_FALSE, 8'h00);

        send_frame(8'h3C, 1'b0, 1'b0, fall);
        expect_frame("ferr3c", fall, K_FERR, 8'h00);
        tick(2000);
        check("break_ferr_n", q_ferr.size(), 0);
        check("break_act_n", q_arise.size(), 0);
        RX = 1'b1;
        tick(10);
        clear_events();

        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, fall);
        expect_frame("ovr_first", fall, K_GOOD, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0, fall);
        expect_frame("ovr_second", fall, K_OVR, 8'h00);
        check("ovr_data_held", int'(data), 8'h11);
        check("ovr_valid_held", int'(valid), 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("ovr_take_valid", int'(valid), 0);
        check("ovr_take_data", int'(data), 8'h11);
        tick(10);
        clear_events();

        send_frame(8'h11, 1'b1, 1'b0, fall);
        expect_frame("swap_first", fall, K_GOOD, 8'h11);
        f2 = cyc;
        fork
            send_frame(8'h22, 1'b1, 1'b0, dummy);
            begin
                tick(2 + H + 9 * N);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        expect_frame("swap_second", f2, K_ABSORB, 8'h00);
        check("swap_data", int'(data), 8'h22);
        check("swap_valid", int'(valid), 1);
        ready = 1'b1;
        tick(1);
        check("swap_take_valid", int'(valid), 0);
        tick(10);

        fall = cyc;
        RX = 1'b0;
        tick(N);
        RX = 1'b1;
        tick(4 * N + H);
        rst = 1'b1;
        tick(2);
        check("midrst_active", int'(rx_active), 0);
        check("midrst_valid", int'(valid), 0);
        rst = 1'b0;
        tick(5 * N);
        clear_events();
        send_frame(8'h5A, 1'b1, 1'b0, fall);
        expect_frame("after_rst", fall, K_GOOD, 8'h5A);
        tick(10);

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h5A, 1'b1, 1'b1, fall);
        expect_frame("maj_glitch", fall, K_GOOD, 8'h5A);
        tick(10);
`endif

        for (int it = 0; it < 12; it++) begin
            mode = $urandom_range(0, 9);
            b    = 8'($urandom);
            gap  = $urandom_range(0, 15);
            if (mode == 0) begin
                glen = $urandom_range(1, H - 8);
                fall = cyc;
                RX = 1'b0;
                tick(glen);
                RX = 1'b1;
                tick(H + 10);
                expect_frame($sformatf("rnd%0d_false", it), fall, K_FALSE, 8'h00);
            end else if (mode == 1) begin
                send_frame(b, 1'b0, 1'b0, fall);
                expect_frame($sformatf("rnd%0d_ferr", it), fall, K_FERR, 8'h00);
                RX = 1'b1;
                tick(3);
            end else begin
                send_frame(b, 1'b1, 1'b0, fall);
                expect_frame($sformatf("rnd%0d_good", it), fall, K_GOOD, b);
            end
            RX = 1'b1;
            if (gap > 0) tick(gap);
        end

        tick(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial input: synchronises the asynchronous `RX` pin, detects and validates start bits, samples eight data bits LSB-first at mid-bit and checks the stop bit. Each good byte goes into a one-entry holding register and is handed to the consumer with a valid/ready handshake. It is the receive-side counterpart of the UART transmitter and uses the same bit period, so a loopback of the two on one board runs at matching baud.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104: clock cycles per bit (12 MHz / 115200). Legal range is ≥ 8.

Ports:
- `CLK` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `RX` input 1: serial line, idle high, asynchronous to `CLK`.
- `data` output 8: received byte. Stable while `valid` is high.
- `valid` output 1: `data` holds an unconsumed byte.
- `ready` input 1: consumer accepts the byte when `valid & ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the holding register is full.
- `rx_active` output 1: high in any state other than IDLE.

## Operation
- `RX` passes through a 2-FF synchroniser. `rxs` is the synchronised value. All decisions use `rxs` or its majority form (see Configuration).
- The state machine has four states: IDLE, START, DATA, STOP.
- **IDLE**: a high→low transition on `rxs` loads the bit counter with H = CLKS_PER_BIT/2 (truncated) and moves to START.
- **START**: when the counter expires, sample the line.
  - Low: reload the counter to CLKS_PER_BIT, clear the bit index, go to DATA.
  - High: false start, return to IDLE. No outputs change.
- **DATA**: each expiry samples one bit into the shift register (shift right, sample enters bit 7) and reloads the counter. After the 8th bit, go to STOP.
- **STOP**: at expiry, sample the line and return to IDLE.
  - Sample 1: deliver the byte.
  - Sample 0: pulse `frame_err` and discard the byte.
  - IDLE re-arms only on a fresh high→low edge, so a held-low break produces exactly one `frame_err`.
- **Delivery**, evaluated in priority order:
  - `valid`=0: load `data`, set `valid`.
  - `valid`=1 and `ready`=1 in the same cycle: load the new byte, `valid` stays 1, no overrun.
  - `valid`=1 and `ready`=0: keep the old byte and pulse `overrun`.
- `valid` clears on the cycle after `valid & ready`, unless a delivery occurs in that cycle.
- The bit counter is `$clog2(CLKS_PER_BIT+1)` bits wide, counts down, and never wraps in use. The bit index is 3 bits.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `overrun`=0, `rx_active`=0. Reset also clears the state (IDLE), the counter and the synchroniser (to 1).
- Reset mid-frame discards the partial byte. After release, the receiver waits for a new falling edge.
- Latency: the pin edge appears on `rxs` 2 cycles later; call that cycle t0.
  - Start sample at t0+H.
  - Data bit i (0..7) sampled at t0+H+(i+1)·N, where N = CLKS_PER_BIT.
  - Stop bit sampled at t0+H+9N.
  - `valid` or `frame_err` rises at t0+H+9N+1. With defaults this is t0+989.
- `rx_active` rises at t0+1 and falls at t0+H+9N+1.
- A new start edge is accepted from the cycle after the STOP sample, giving half a bit of resynchronisation margin for back-to-back frames.
- `ready` may be held high permanently; throughput is then one byte per frame.

## Configuration
- `UART_RX_MAJORITY_EN` defined: every sample (start, data, stop) is the 2-of-3 majority of `rxs` over the sample cycle and the two cycles before it. A single-cycle glitch at a sample point is rejected. Latency is unchanged.
- Macro undefined: each sample is the single `rxs` value on the sample cycle. The history register is not built.

## Structure
- Shared package `uart_pkg` holds:
  - the state encodings `ST_IDLE`=2'b00, `ST_START`=2'b01, `ST_DATA`=2'b10, `ST_STOP`=2'b11;
  - `UART_DEFAULT_CLKS_PER_BIT`=104, shared with the transmitter.
- One sub-module, `uart_rx_sync`, contains the 2-FF synchroniser and, under the macro, the 3-sample majority history. It outputs the sampled line bit. All FSM, counter and handshake logic stays in `uart_rx`.

## Test plan
- Byte 0xA5 sent at 104 clocks/bit with `ready`=1: `valid` pulses one cycle at t0+989, `data`=0xA5, `frame_err`=0.
- 30-cycle low glitch on an idle line: `rx_active` goes high then falls at t0+53, with no `valid` and no `frame_err`.
- Byte 0x3C sent with the stop bit forced low: `frame_err` pulses once at t0+989, `valid` stays 0. The line then held low for 2000 cycles gives no further pulses.
- Bytes 0x11 then 0x22 back-to-back with `ready`=0: `data`=0x11, `valid`=1, `overrun` pulses at the second delivery. Raising `ready` then clears `valid` with `data` still 0x11.
- Same pair with `ready` asserted exactly on the second delivery cycle: `data` becomes 0x22, `valid` stays 1, no `overrun`.
- `rst` pulsed during bit 4 of 0xFF, then 0x5A sent: only 0x5A is delivered. With `UART_RX_MAJORITY_EN`, a 1-cycle inverted glitch at each data sample point of 0x5A still yields 0x5A.
